// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode encodings and the NOP word.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  localparam logic [5:0] OPC_ADD  = 6'b000001;
  localparam logic [5:0] OPC_SUB  = 6'b000010;
  localparam logic [5:0] OPC_MUL  = 6'b000011;
  localparam logic [5:0] OPC_LUI  = 6'b000100;
  localparam logic [5:0] OPC_ADDI = 6'b000101;
  localparam logic [5:0] OPC_LW   = 6'b000110;
  localparam logic [5:0] OPC_SW   = 6'b000111;
  localparam logic [5:0] OPC_J    = 6'b001000;
  localparam logic [5:0] OPC_BEQ  = 6'b001001;
  localparam logic [5:0] OPC_BNE  = 6'b001010;

  localparam logic [31:0] INSTR_NOP = 32'h0;

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between two stages: instruction, PC+4 and valid, with
// hold (stall) and flush (clear to bubble) controls. Flush wins over hold.
module if_id_reg #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic [DATA_W-1:0] nxt_instr,
  input  logic [ADDR_W-1:0] nxt_pc4,
  input  logic              nxt_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc4,
  output logic              valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= '0;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= nxt_instr;
      pc4   <= nxt_pc4;
      valid <= nxt_valid;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, resolves unconditional jumps locally
// and registers the fetched word into IF/ID, honouring stall and redirect.
module if_fetch_stage #(
  parameter int                     ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                     DATA_W   = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0,
  parameter int                     PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_instr,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic              ifid_valid,
  output logic [15:0]       fetch_count
);

  import cpu_pkg::*;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc4_p0;
  logic [ADDR_W-1:0] jmp_target_p0;
  logic              jmp_p0;

  logic              ifid_hold;
  logic              ifid_flush;
  logic [DATA_W-1:0] ifid_nxt_instr;
  logic [ADDR_W-1:0] ifid_nxt_pc4;
  logic              ifid_nxt_valid;
  logic              count_inc;

  // Bits the fetch stage never looks at; kept visible to lint as unused.
  logic unused_bits;
  assign unused_bits = ^{im_instr[25:6], redirect_target[1:0]};

  assign im_addr       = pc_p0;
  assign pc4_p0        = pc_p0 + ADDR_W'(PC_STEP);
  assign jmp_p0        = (im_instr[31:26] == OPC_J);
  assign jmp_target_p0 = pc4_p0 + ADDR_W'({im_instr[5:0], 2'b00});

  always_comb begin
    pc_nxt         = pc_p0;
    ifid_hold      = 1'b0;
    ifid_flush     = 1'b0;
    ifid_nxt_instr = INSTR_NOP;
    ifid_nxt_pc4   = pc4_p0;
    ifid_nxt_valid = 1'b0;
    count_inc      = 1'b0;
    if (redirect_valid) begin
      pc_nxt     = {redirect_target[ADDR_W-1:2], 2'b00};
      ifid_flush = 1'b1;
    end else if (stall) begin
      ifid_hold = 1'b1;
    end else if (jmp_p0) begin
      // Jump is consumed here: a single bubble carrying the jump's PC+4.
      pc_nxt = jmp_target_p0;
    end else begin
      pc_nxt         = pc4_p0;
      ifid_nxt_instr = im_instr;
      ifid_nxt_valid = 1'b1;
      count_inc      = 1'b1;
    end
  end

  // ---- IF stage: PC and delivered-instruction counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0       <= RESET_PC;
      fetch_count <= 16'd0;
    end else begin
      pc_p0 <= pc_nxt;
      if (count_inc) fetch_count <= sat_inc(fetch_count);
    end
  end

  // ---- IF/ID boundary ----
  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (ifid_hold),
    .flush     (ifid_flush),
    .nxt_instr (ifid_nxt_instr),
    .nxt_pc4   (ifid_nxt_pc4),
    .nxt_valid (ifid_nxt_valid),
    .instr     (ifid_instr),
    .pc4       (ifid_pc4),
    .valid     (ifid_valid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a combinational instruction memory.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_target;
  logic [7:0]  im_addr;
  logic [31:0] im_instr;
  logic [31:0] ifid_instr;
  logic [7:0]  ifid_pc4;
  logic        ifid_valid;
  logic [15:0] fetch_count;

  logic [31:0] mem [64];
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] ADDI_A = 32'h14210003;  // addi r1,r1,3
  localparam logic [31:0] ADDI_B = 32'h14210005;
  localparam logic [31:0] J7     = 32'h20000007;
  localparam logic [31:0] W44    = 32'h04221800;
  localparam logic [31:0] W48    = 32'h08431000;
  localparam logic [31:0] W56    = 32'h0C642000;

  assign im_instr = mem[im_addr[7:2]];

  if_fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .im_addr         (im_addr),
    .im_instr        (im_instr),
    .ifid_instr      (ifid_instr),
    .ifid_pc4        (ifid_pc4),
    .ifid_valid      (ifid_valid),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 8'd0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[1] = ADDI_A; mem[2] = ADDI_B; mem[3] = J7; mem[11] = W44; mem[12] = W48;
    mem[14] = W56;
    mem[22] = 32'h20000001;  // jump at 88, imm 1 -> 96
    repeat (2) step();
    n_checks++; if (im_addr !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", im_addr); end
    n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ifid_valid); end
    n_checks++; if (ifid_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", ifid_instr); end
    n_checks++; if (ifid_pc4 !== 8'd0) begin n_fail++; $display("FAIL reset_pc4: got %0d want 0", ifid_pc4); end
    n_checks++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential_and_jump();
    step();  // fetch NOP at 0
    n_checks++; if (im_addr !== 8'd4) begin n_fail++; $display("FAIL seq0_addr: got %0d want 4", im_addr); end
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 8'd4) begin n_fail++; $display("FAIL seq0_ifid: got v=%b pc4=%0d want v=1 pc4=4", ifid_valid, ifid_pc4); end
    step();  // fetch addi at 4
    n_checks++; if (ifid_instr !== ADDI_A) begin n_fail++; $display("FAIL seq_addi_instr: got %h want %h", ifid_instr, ADDI_A); end
    n_checks++; if (ifid_pc4 !== 8'd8 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL seq_addi_pc4: got pc4=%0d v=%b want 8/1", ifid_pc4, ifid_valid); end
    n_checks++; if (fetch_count !== 16'd2) begin n_fail++; $display("FAIL seq_addi_count: got %0d want 2", fetch_count); end
    n_checks++; if (im_addr !== 8'd8) begin n_fail++; $display("FAIL seq_addr8: got %0d want 8", im_addr); end
    step();  // fetch addi at 8
    n_checks++; if (im_addr !== 8'd12 || ifid_instr !== ADDI_B) begin n_fail++; $display("FAIL seq_addr12: got addr=%0d instr=%h want 12/%h", im_addr, ifid_instr, ADDI_B); end
    step();  // jump at 12 -> 44, bubble
    n_checks++; if (im_addr !== 8'd44) begin n_fail++; $display("FAIL jmp_target: got %0d want 44", im_addr); end
    n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin n_fail++; $display("FAIL jmp_bubble: got v=%b instr=%h want 0/0", ifid_valid, ifid_instr); end
    n_checks++; if (ifid_pc4 !== 8'd16) begin n_fail++; $display("FAIL jmp_pc4: got %0d want 16", ifid_pc4); end
    n_checks++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL jmp_count: got %0d want 3", fetch_count); end
    step();  // fetch at 44
    n_checks++; if (im_addr !== 8'd48 || ifid_instr !== W44 || ifid_pc4 !== 8'd48) begin n_fail++; $display("FAIL after_jmp: got addr=%0d instr=%h pc4=%0d want 48/%h/48", im_addr, ifid_instr, ifid_pc4, W44); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (im_addr !== 8'd48 || ifid_instr !== W44 || ifid_pc4 !== 8'd48 || ifid_valid !== 1'b1 || fetch_count !== 16'd4) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got addr=%0d instr=%h pc4=%0d v=%b cnt=%0d want 48/%h/48/1/4", i, im_addr, ifid_instr, ifid_pc4, ifid_valid, fetch_count, W44);
      end
    end
    stall = 1'b0;
    step();
    n_checks++; if (im_addr !== 8'd52 || ifid_instr !== W48 || fetch_count !== 16'd5) begin n_fail++; $display("FAIL stall_resume: got addr=%0d instr=%h cnt=%0d want 52/%h/5", im_addr, ifid_instr, fetch_count, W48); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (im_addr !== 8'd0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || fetch_count !== 16'd0) begin n_fail++; $display("FAIL async_reset: got addr=%0d v=%b instr=%h cnt=%0d want 0/0/0/0", im_addr, ifid_valid, ifid_instr, fetch_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (im_addr !== 8'd0 || fetch_count !== 16'd0) begin n_fail++; $display("FAIL release: got addr=%0d cnt=%0d want 0/0", im_addr, fetch_count); end
    step();
    n_checks++; if (im_addr !== 8'd4 || ifid_pc4 !== 8'd4 || fetch_count !== 16'd1) begin n_fail++; $display("FAIL first_fetch: got addr=%0d pc4=%0d cnt=%0d want 4/4/1", im_addr, ifid_pc4, fetch_count); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_target = 8'd56;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (im_addr !== 8'd56 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL redir56: got addr=%0d v=%b want 56/0", im_addr, ifid_valid); end
    step();
    n_checks++; if (im_addr !== 8'd60 || ifid_valid !== 1'b1 || ifid_instr !== W56 || fetch_count !== 16'd2) begin n_fail++; $display("FAIL seq56: got addr=%0d v=%b instr=%h cnt=%0d want 60/1/%h/2", im_addr, ifid_valid, ifid_instr, fetch_count, W56); end
    redirect_valid = 1'b1; redirect_target = 8'd89; stall = 1'b1;
    step();
    n_checks++; if (im_addr !== 8'd88) begin n_fail++; $display("FAIL redir_stall_addr: got %0d want 88", im_addr); end
    n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 8'd0) begin n_fail++; $display("FAIL redir_stall_flush: got v=%b instr=%h pc4=%0d want 0/0/0", ifid_valid, ifid_instr, ifid_pc4); end
    n_checks++; if (fetch_count !== 16'd2) begin n_fail++; $display("FAIL redir_stall_count: got %0d want 2", fetch_count); end
    stall = 1'b0; redirect_target = 8'd21;  // jump sits at 88; redirect must win
    step();
    redirect_valid = 1'b0;
    n_checks++; if (im_addr !== 8'd20 || ifid_valid !== 1'b0 || ifid_pc4 !== 8'd0) begin n_fail++; $display("FAIL redir_jmp: got addr=%0d v=%b pc4=%0d want 20/0/0", im_addr, ifid_valid, ifid_pc4); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_target = 8'd244;
    step();
    redirect_valid = 1'b0;
    step();
    n_checks++; if (im_addr !== 8'd248) begin n_fail++; $display("FAIL wrap248: got %0d want 248", im_addr); end
    step();
    n_checks++; if (im_addr !== 8'd252) begin n_fail++; $display("FAIL wrap252: got %0d want 252", im_addr); end
    step();
    n_checks++; if (im_addr !== 8'd0 || ifid_pc4 !== 8'd0 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL wrap0: got addr=%0d pc4=%0d v=%b want 0/0/1", im_addr, ifid_pc4, ifid_valid); end
    step();
    n_checks++; if (im_addr !== 8'd4 || fetch_count !== 16'd6) begin n_fail++; $display("FAIL wrap4: got addr=%0d cnt=%0d want 4/6", im_addr, fetch_count); end
    mem[63] = 32'h20000002;  // jump at 252, imm 2
    redirect_valid = 1'b1; redirect_target = 8'd252;
    step();
    redirect_valid = 1'b0;
    n_checks++; if (im_addr !== 8'd252) begin n_fail++; $display("FAIL redir252: got %0d want 252", im_addr); end
    step();
    n_checks++; if (im_addr !== 8'd8 || ifid_valid !== 1'b0 || ifid_pc4 !== 8'd0 || fetch_count !== 16'd6) begin n_fail++; $display("FAIL wrap_jmp: got addr=%0d v=%b pc4=%0d cnt=%0d want 8/0/0/6", im_addr, ifid_valid, ifid_pc4, fetch_count); end
  endtask

  initial begin
    test_reset();
    test_sequential_and_jump();
    test_stall();
    test_async_reset();
    test_redirect();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
